hexdisplay_mux: RTL and testbench

Parametrised, time-multiplexed hex driver for common-cathode/anode 7-segment modules; generalises our fixed 4-digit hex display.
- Digit count, scan rate and pin polarity are parameters.
- Adds a tear-free load handshake (shadow register committed at frame boundary), leading-zero blanking and per-digit decimal points.
- Sits between datapath results (e.g. CORDIC sine/cosine) and PMOD pins.

---
 rtl/hexdisplay_mux.sv | 159 +++++++++++++++
 tb/tb_hexdisplay_mux.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hexdisplay_mux.sv
// Time-multiplexed hex driver for multi-digit 7-segment modules with tear-free load and leading-zero blanking.
// Optional HEXMUX_DIM_EN adds a 4-bit brightness input that gates the strobe duty cycle.
module hexdisplay_mux #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 12,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  enable,
    input  logic                  blank_lz,
`ifdef HEXMUX_DIM_EN
    input  logic [3:0]            bright,
`endif
    output logic                  pending,
    output logic [6:0]            segment,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     omask
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

    logic [REFRESH_DIV-1:0] prescaler_reg;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [4*DIGITS-1:0]    shadow_reg, disp_reg;
    logic [DIGITS-1:0]      shadow_dp_reg, disp_dp_reg;
    logic                   pending_reg;
    logic [6:0]             seg_reg;
    logic                   seg_dp_reg;
    logic [DIGITS-1:0]      omask_reg;

    logic                   tick, boundary, strobe_on;
    logic [DIGITS-1:0]      blank, sel;
    logic [3:0]             cur_nibble;
    logic                   cur_blank, cur_dp;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        case (h)
            4'h0: return 7'h7E;
            4'h1: return 7'h30;
            4'h2: return 7'h6D;
            4'h3: return 7'h79;
            4'h4: return 7'h33;
            4'h5: return 7'h5B;
            4'h6: return 7'h5F;
            4'h7: return 7'h70;
            4'h8: return 7'h7F;
            4'h9: return 7'h7B;
            4'hA: return 7'h77;
            4'hB: return 7'h1F;
            4'hC: return 7'h4E;
            4'hD: return 7'h3D;
            4'hE: return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    assign tick     = &prescaler_reg;
    assign boundary = tick && (idx_reg == LAST_IDX);

    always_comb begin
        idx_next = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prescaler_reg <= '0;
            idx_reg       <= '0;
        end else begin
            prescaler_reg <= prescaler_reg + REFRESH_DIV'(1);
            idx_reg       <= idx_next;
        end
    end

    // Display only ever changes at a frame boundary, so a frame never mixes two values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_reg    <= '0;
            shadow_dp_reg <= '0;
            disp_reg      <= '0;
            disp_dp_reg   <= '0;
            pending_reg   <= 1'b0;
        end else if (load && boundary) begin
            disp_reg      <= value;
            disp_dp_reg   <= dp;
            pending_reg   <= 1'b0;
        end else if (load) begin
            shadow_reg    <= value;
            shadow_dp_reg <= dp;
            pending_reg   <= 1'b1;
        end else if (boundary && pending_reg) begin
            disp_reg      <= shadow_reg;
            disp_dp_reg   <= shadow_dp_reg;
            pending_reg   <= 1'b0;
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_lsd
            assign blank[gi] = 1'b0;
        end else begin : g_upper
            assign blank[gi] = blank_lz && (disp_reg[4*DIGITS-1:4*gi] == '0);
        end
        assign sel[gi] = (idx_reg == IDX_W'(gi));
    end

    always_comb begin
        cur_nibble = '0;
        cur_blank  = 1'b0;
        cur_dp     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) begin
                cur_nibble = disp_reg[4*i +: 4];
                cur_blank  = blank[i];
                cur_dp     = disp_dp_reg[i];
            end
        end
    end

`ifdef HEXMUX_DIM_EN
    assign strobe_on = (prescaler_reg[REFRESH_DIV-1 -: 4] <= bright);
`else
    assign strobe_on = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_reg    <= '0;
            seg_dp_reg <= 1'b0;
            omask_reg  <= '0;
        end else if (enable && strobe_on) begin
            seg_reg    <= cur_blank ? 7'h00 : hex_decode(cur_nibble);
            seg_dp_reg <= cur_dp;
            omask_reg  <= sel;
        end else begin
            seg_reg    <= '0;
            seg_dp_reg <= 1'b0;
            omask_reg  <= '0;
        end
    end

    // Registers hold active-high "lit"; pin polarity is a constant inversion.
    assign segment = seg_reg ^ {7{SEG_INV}};
    assign seg_dp  = seg_dp_reg ^ SEG_INV;
    assign omask   = omask_reg ^ {DIGITS{DIG_INV}};
    assign pending = pending_reg;

endmodule

// File: tb/tb_hexdisplay_mux.sv
// Scoreboard bench for hexdisplay_mux: a cycle-level reference model queues expected pins, a monitor compares them.
module tb_hexdisplay_mux;
    localparam int DIGITS = 4;
    localparam int RDIV   = 2;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp;
    logic        enable;
    logic        blank_lz;
    logic        pending;
    logic [6:0]  segment;
    logic        seg_dp;
    logic [3:0]  omask;
`ifdef HEXMUX_DIM_EN
    logic [3:0]  bright = 4'hF;
`endif

    hexdisplay_mux #(
        .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .value(value), .load(load), .dp(dp),
        .enable(enable), .blank_lz(blank_lz),
`ifdef HEXMUX_DIM_EN
        .bright(bright),
`endif
        .pending(pending), .segment(segment), .seg_dp(seg_dp), .omask(omask)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0] seg;
        logic       sdp;
        logic [3:0] om;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    // Reference model: t counts clocks since reset; one scan slot lasts 2^RDIV clocks.
    int          t;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_disp_dp, m_shadow_dp;
    logic        m_pend;
    int          m_slot, m_phase;
    logic        m_bnd;
    logic [3:0]  m_nib;
    exp_t        e;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            t = 0; m_disp = 0; m_shadow = 0; m_disp_dp = 0; m_shadow_dp = 0; m_pend = 0;
            q.delete();
        end else begin
            m_phase = t % (1 << RDIV);
            m_slot  = (t / (1 << RDIV)) % DIGITS;
            m_nib   = 4'((m_disp >> (4 * m_slot)) & 16'hF);
            e.seg = 7'h00; e.sdp = 1'b0; e.om = 4'h0;
            if (enable) begin
                e.om  = 4'(1 << m_slot);
                e.sdp = m_disp_dp[m_slot];
                if (blank_lz && m_slot >= 1 && (m_disp >> (4 * m_slot)) == 16'h0) e.seg = 7'h00;
                else e.seg = seg_tab[m_nib];
            end
            m_bnd = (m_phase == (1 << RDIV) - 1) && (m_slot == DIGITS - 1);
            if (load && m_bnd) begin
                m_disp = value; m_disp_dp = dp; m_pend = 0;
            end else if (load) begin
                m_shadow = value; m_shadow_dp = dp; m_pend = 1;
            end else if (m_bnd && m_pend) begin
                m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pend = 0;
            end
            e.pend = m_pend;
            q.push_back(e);
            t++;
        end
    end

    exp_t got;
    always @(negedge CLK) begin
        if (RST_N && q.size() > 0) begin
            got = q.pop_front();
            check("segment", {9'h0, segment}, {9'h0, got.seg});
            check("seg_dp",  {15'h0, seg_dp}, {15'h0, got.sdp});
            check("omask",   {12'h0, omask},  {12'h0, got.om});
            check("pending", {15'h0, pending}, {15'h0, got.pend});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(negedge CLK);
        value = v; dp = d; load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
    endtask

    // Issue a load so that it is sampled at frame phase p (0..15).
    task automatic load_at_phase(input int p, input logic [15:0] v, input logic [3:0] d);
        int guard = 0;
        @(negedge CLK);
        while ((t % 16) != p && guard < 40) begin
            @(negedge CLK);
            guard++;
        end
        value = v; dp = d; load = 1'b1;
        @(negedge CLK);
        load = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; value = '0; load = 1'b0; dp = '0; enable = 1'b1; blank_lz = 1'b0;
        step(3);
        RST_N = 1'b1;
        step(7);

        // Asynchronous reset mid-scan with a load pending.
        do_load(16'h5555, 4'hF);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("rst_segment", {9'h0, segment}, 16'h0);
        check("rst_seg_dp",  {15'h0, seg_dp}, 16'h0);
        check("rst_omask",   {12'h0, omask},  16'h0);
        check("rst_pending", {15'h0, pending}, 16'h0);
        @(posedge CLK);
        #1;
        check("rst_hold_omask", {12'h0, omask}, 16'h0);
        #1 RST_N = 1'b1;

        do_load(16'h1234, 4'h0);
        step(40);
        load_at_phase(6, 16'hABCD, 4'h0);
        step(36);
        load_at_phase(15, 16'h5678, 4'b0001);
        step(36);

        // Two loads two clocks apart inside one frame.
        load_at_phase(2, 16'h1111, 4'h0);
        do_load(16'h2222, 4'h0);
        step(36);

        blank_lz = 1'b1;
        do_load(16'h0070, 4'h0);
        step(36);
        do_load(16'h0000, 4'h0);
        step(36);
        blank_lz = 1'b0;
        step(20);

        do_load(16'h1234, 4'b0100);
        step(20);
        for (int i = 0; i < 6; i++) begin
            enable = ~enable;
            step(3 + i);
        end
        enable = 1'b1;
        step(20);

        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            load     = ($urandom % 8) == 0;
            value    = 16'($urandom);
            dp       = 4'($urandom);
            enable   = ($urandom % 6) != 0;
            blank_lz = 1'($urandom);
        end
        @(negedge CLK);
        load = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
